// File: rtl/rr_stream_mux_2to1.sv
// rr_stream_mux_2to1
// Two-input valid/ready stream multiplexer with round-robin arbitration and a
// registered output stage. Sustains one beat per cycle when out_ready stays high.
//
// Optional feature macro: RR_STREAM_MUX_PACKET_LOCK_EN
//   Defined   : arbitration is packet-granular. Once a channel starts a packet,
//               it keeps the grant until it sends a beat with last=1.
//   Undefined : arbitration is beat-granular. The last flag is only forwarded.
module rr_stream_mux_2to1 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in0_last,
    input  logic             in1_valid,
    output logic             in1_ready,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             out_src
);

    // Round-robin pointer: the channel that wins when both request.
    logic             ptr;
    logic             load_en;
    logic [1:0]       grant;
    logic             xfer;
    logic             xfer_src;
    logic [WIDTH-1:0] xfer_data;
    logic             xfer_last;

`ifdef RR_STREAM_MUX_PACKET_LOCK_EN
    // Packet lock: while set, only lock_src may be granted.
    logic             locked;
    logic             lock_src;
`endif

    // The output register can take a new beat when empty or being drained.
    assign load_en = ~out_valid | out_ready;

    // Combinational grant from the requests, the pointer and the packet lock.
    always_comb begin
        grant = 2'b00;
        case ({in1_valid, in0_valid})
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
`ifdef RR_STREAM_MUX_PACKET_LOCK_EN
        // Mid-packet the owner keeps the grant even through its valid gaps.
        if (locked) begin
            grant = lock_src ? 2'b10 : 2'b01;
        end
`endif
    end

    // No handshake can complete while reset is asserted.
    assign in0_ready = load_en & grant[0] & ~rst;
    assign in1_ready = load_en & grant[1] & ~rst;

    // Select the beat being transferred this cycle (at most one ready is high).
    always_comb begin
        xfer      = 1'b0;
        xfer_src  = 1'b0;
        xfer_data = in0_data;
        xfer_last = in0_last;
        if (in0_valid & in0_ready) begin
            xfer = 1'b1;
        end else if (in1_valid & in1_ready) begin
            xfer      = 1'b1;
            xfer_src  = 1'b1;
            xfer_data = in1_data;
            xfer_last = in1_last;
        end
    end

    // Output register: load on transfer, empty on drain without refill, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_src   <= 1'b0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= xfer_data;
            out_last  <= xfer_last;
            out_src   <= xfer_src;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Arbitration state: pointer (and packet lock) advance only on a transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'b0;
`ifdef RR_STREAM_MUX_PACKET_LOCK_EN
            locked   <= 1'b0;
            lock_src <= 1'b0;
`endif
        end else if (xfer) begin
`ifdef RR_STREAM_MUX_PACKET_LOCK_EN
            if (xfer_last) begin
                locked <= 1'b0;
                ptr    <= ~xfer_src;
            end else begin
                locked   <= 1'b1;
                lock_src <= xfer_src;
            end
`else
            ptr <= ~xfer_src;
`endif
        end
    end

endmodule

// File: doc/rr_stream_mux_2to1.md
# rr_stream_mux_2to1

Two-input, one-output valid/ready stream multiplexer with round-robin selection between its input channels and a registered output stage. It sits downstream of the request sources: each input channel's `valid` acts as a request, the internal round-robin pointer chooses one channel, and the chosen beat is forwarded into a single output channel. The output is registered for timing, and the block sustains one beat per cycle under continuous `out_ready`.

## Interface
- `WIDTH`, default 8: payload width in bits.
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high; sampled on `posedge clk`.
- `in0_valid`  in  1  channel 0 beat present.
- `in0_ready`  out  1  channel 0 beat accepted this cycle when high together with `in0_valid`.
- `in0_data`  in  WIDTH  channel 0 payload.
- `in0_last`  in  1  channel 0 end-of-packet marker.
- `in1_valid`, `in1_ready`, `in1_data`, `in1_last`: same as channel 0, for channel 1.
- `out_valid`  out  1  output register holds a beat.
- `out_ready`  in  1  downstream accepts the beat.
- `out_data`  out  WIDTH  forwarded payload.
- `out_last`  out  1  forwarded end-of-packet marker.
- `out_src`  out  1  index of the channel that produced the current output beat.

## Operation
- `load_en = ~out_valid | out_ready`. This means the output register is empty or is being drained this cycle.
- Round-robin pointer `ptr` (1 bit) names the channel that is next in line.
- Grant is combinational:
  - Only one channel is valid: grant that channel.
  - Both channels are valid: grant channel `ptr`.
  - Neither channel is valid: no grant.
- `inX_ready = load_en & grant[X] & ~rst`. At most one ready is high in any cycle.
- Transfer on channel X (`inX_valid & inX_ready`):
  - Output register loads `inX_data`, `inX_last`, and `out_src = X`.
  - `out_valid` is set to 1.
  - `ptr` is set to `~X`.
- `load_en` high with no transfer, and `out_ready` high: `out_valid` clears to 0. Data fields hold their previous values.
- `out_valid` high and `out_ready` low: all output fields hold stable. Both input readys are 0.
- `ptr` changes only on a transfer. Idle cycles and stalled cycles leave it unchanged.
- Example with `out_ready` held at 1, showing input valids {1,0} and the resulting grants:
  - Valids: 01 00 10 11 11 00 11 00 11 11.
  - Grants: 01 00 10 01 10 00 01 00 10 01.

## Timing
- Latency: one cycle from input handshake to `out_valid`.
- Throughput: one beat per cycle when `out_ready` is held at 1. There are no bubbles.
- Reset values:
  - `out_valid=0`, `out_data=0`, `out_last=0`, `out_src=0`.
  - `ptr=0`, so channel 0 is favoured first.
  - Lock state cleared.
  - `in0_ready=in1_ready=0` while `rst` is high.
- Reset during operation: any beat held in the output register is discarded. No handshake completes in a cycle where `rst` is high.
- Simultaneous drain and load in the same cycle is legal and required.
- Input `valid` may drop without a handshake. The block must not depend on valid stability for grant correctness.

## Configuration
- Macro: `RR_STREAM_MUX_PACKET_LOCK_EN`.
- **Defined**: arbitration is packet-granular.
  - A transfer with `last=0` from channel X sets `locked=1` and `lock_src=X`.
  - While `locked`, only `lock_src` can be granted, even if it is not valid. The other channel's ready stays 0.
  - A transfer from `lock_src` with `last=1` clears `locked`.
  - `ptr` updates only on a `last=1` transfer. It is set to the other channel.
  - A single-beat packet (`last=1` on its first beat) never sets the lock.
- **Undefined**: arbitration is beat-granular as described in Operation.
  - `inX_last` is forwarded to `out_last` only.
  - No lock register is synthesised.

## Test plan
- **Reset and idle.** Hold `rst` for 2 cycles, then drive both valids 0 → `out_valid=0`, `out_data=0`, `out_src=0`, both readys 0.
- **Alternation under contention.** Drive both valids 1 continuously, with `in0_data=0xA0` and `in1_data=0xB1`, and `out_ready=1` → output sequence A0, B1, A0, B1 with `out_src` 0, 1, 0, 1. One beat per cycle, first beat one cycle after the first handshake.
- **Example sequence.** Apply the valid sequence 01 00 10 11 11 00 11 00 11 11 with `out_ready=1` → grants 01 00 10 01 10 00 01 00 10 01.
- **Backpressure.** Fill the output with 0x55 from channel 1, then hold `out_ready=0` for 3 cycles with both valids high → output fields stable at 0x55/`src`=1 and both readys 0. When `out_ready` rises, channel 0 is granted in that same cycle.
- **Reset mid-stream.** Assert `rst` while `out_valid=1`, then release → `out_valid=0` and `ptr=0`. With both valids high, the first grant after release goes to channel 0.
- **Packet lock (macro defined).**
  - Channel 0 sends a 3-beat packet (`last` on beat 3) while `in1_valid=1` throughout → channel 1 gets no grant until after beat 3.
  - Insert a channel 0 valid gap mid-packet → `in1_ready` stays 0 during the gap.
  - Next grant after beat 3 goes to channel 1.
